// File: rtl/cdb_arbiter_if.sv
// Functional-unit result / flush / common-data-bus signal bundle for cdb_arbiter.
// The slave modport is the arbiter; the master modport is the functional units and the ROB flush source.
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32
);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           flush_valid;
    logic [TAG_W-1:0]               flush_tag;
    logic [TAG_W-1:0]               flush_rear_tag;
    logic                           cdb_valid;
    logic [TAG_W-1:0]               cdb_tag;
    logic [DATA_W-1:0]              cdb_data;
    logic [SRC_W-1:0]               cdb_src;

    modport master (
        output req_valid, req_tag, req_data, flush_valid, flush_tag, flush_rear_tag,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        input  req_valid, req_tag, req_data, flush_valid, flush_tag, flush_rear_tag,
        output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding buffer per functional unit, round-robin grant of the
// single registered CDB broadcast, and dropping of results whose ROB tags are squashed by a flush.
module cdb_arbiter #(
    parameter int          NUM_REQ = 4,
    parameter int          TAG_W   = 4,
    parameter int          DATA_W  = 32,
    parameter logic [31:0] MASK    = 32'd7
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);
    localparam int               SRC_W = $clog2(NUM_REQ);
    localparam logic [TAG_W-1:0] TMASK = MASK[TAG_W-1:0];
    localparam logic [TAG_W-1:0] TONE  = TAG_W'(1);
    localparam logic [SRC_W-1:0] SONE  = SRC_W'(1);

    logic [NUM_REQ-1:0] r_full;
    logic [TAG_W-1:0]   r_tag  [NUM_REQ];
    logic [DATA_W-1:0]  r_data [NUM_REQ];
    logic [SRC_W-1:0]   r_ptr;
    logic               r_cdb_valid;
    logic [TAG_W-1:0]   r_cdb_tag;
    logic [DATA_W-1:0]  r_cdb_data;
    logic [SRC_W-1:0]   r_cdb_src;

    logic [TAG_W-1:0]   w_range;
    logic [TAG_W-1:0]   w_rear_inc;
    logic               w_flush_on;
    logic               w_sq_buf [NUM_REQ];
    logic               w_sq_req [NUM_REQ];
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_grant;
    logic [SRC_W-1:0]   w_gnt_idx;
    logic [SRC_W-1:0]   w_cand;
    logic               w_any;

    // Squashed tags are those whose masked distance from flush_tag lies within the flushed span;
    // a span that starts one past the rear is the empty (nothing allocated) case.
    assign w_rear_inc = (bus.flush_rear_tag + TONE) & TMASK;
    assign w_range    = (bus.flush_rear_tag - bus.flush_tag) & TMASK;
    assign w_flush_on = bus.flush_valid && (bus.flush_tag != w_rear_inc);

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        logic [TAG_W-1:0] w_buf_off;
        logic [TAG_W-1:0] w_req_off;

        assign w_buf_off    = (r_tag[gi] - bus.flush_tag) & TMASK;
        assign w_req_off    = (bus.req_tag[gi] - bus.flush_tag) & TMASK;
        assign w_sq_buf[gi] = w_flush_on && (w_buf_off <= w_range);
        assign w_sq_req[gi] = w_flush_on && (w_req_off <= w_range);
        assign w_elig[gi]   = r_full[gi] & ~w_sq_buf[gi];
    end

    always_comb begin
        w_grant   = '0;
        w_gnt_idx = r_ptr;
        w_cand    = r_ptr;
        w_any     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = r_ptr + SRC_W'(k);
            if (!w_any && w_elig[w_cand]) begin
                w_any     = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
        if (w_any) begin
            w_grant[w_gnt_idx] = 1'b1;
        end
    end

    // A granted buffer frees its slot in the same cycle, so a unit can stream one result per cycle.
    assign bus.req_ready = ~r_full | w_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i] && !w_sq_req[i]) begin
                    r_full[i] <= 1'b1;
                    r_tag[i]  <= bus.req_tag[i];
                    r_data[i] <= bus.req_data[i];
                end else if (w_grant[i] || w_sq_buf[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr       <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
            r_cdb_src   <= '0;
        end else begin
            r_cdb_valid <= w_any;
            if (w_any) begin
                r_cdb_tag  <= r_tag[w_gnt_idx];
                r_cdb_data <= r_data[w_gnt_idx];
                r_cdb_src  <= w_gnt_idx;
                r_ptr      <= w_gnt_idx + SONE;
            end
        end
    end

    assign bus.cdb_valid = r_cdb_valid;
    assign bus.cdb_tag   = r_cdb_tag;
    assign bus.cdb_data  = r_cdb_data;
    assign bus.cdb_src   = r_cdb_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, a mid-operation reset sequence, and randomized
// traffic checked against a behavioural model of buffers, round-robin grant and flush ranges.
module tb_cdb_arbiter;
    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 4;
    localparam int DATA_W  = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

    cdb_arbiter #(
        .NUM_REQ(NUM_REQ),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W),
        .MASK   (32'd7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit               rst_first;
        logic [3:0]       valid;
        logic [3:0][3:0]  tag;
        logic [3:0][31:0] data;
        logic             fv;
        logic [3:0]       ft;
        logic [3:0]       frt;
        logic [3:0]       e_ready;
        logic             e_cv;
        logic [3:0]       e_ct;
        logic [31:0]      e_cd;
        logic [1:0]       e_cs;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state
    bit          m_full [4];
    logic [3:0]  m_tag  [4];
    logic [31:0] m_data [4];
    int          m_ptr;
    logic        m_cv;
    logic [3:0]  m_ct;
    logic [31:0] m_cd;
    logic [1:0]  m_cs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dv(input int u, input logic [3:0] t);
        return 32'hC0DE_0000 | (32'(u) << 8) | {28'h0, t};
    endfunction

    function automatic logic [127:0] dd(input logic [15:0] tg);
        logic [3:0][31:0] d;
        for (int i = 0; i < 4; i++) d[i] = dv(i, tg[i*4 +: 4]);
        return d;
    endfunction

    // Squash membership found by walking the ROB ring from the first squashed tag to the rear.
    function automatic bit in_flush(input logic [3:0] t, input logic [3:0] ft,
                                    input logic [3:0] frt, input logic fv);
        int c;
        if (!fv) return 1'b0;
        if (int'(ft & 4'd7) == ((int'(frt & 4'd7) + 1) % 8)) return 1'b0;
        c = int'(ft & 4'd7);
        for (int n = 0; n < 8; n++) begin
            if (c == int'(t & 4'd7)) return 1'b1;
            if (c == int'(frt & 4'd7)) return 1'b0;
            c = (c + 1) % 8;
        end
        return 1'b0;
    endfunction

    task automatic add_row(input bit rf, input logic [3:0] vl, input logic [15:0] tg,
                           input logic [127:0] d, input logic fv, input logic [3:0] ft,
                           input logic [3:0] frt, input logic [3:0] er, input logic ecv,
                           input logic [3:0] ect, input logic [31:0] ecd, input logic [1:0] ecs);
        vec_t v;
        v.rst_first = rf;   v.valid = vl;   v.tag = tg;     v.data = d;
        v.fv = fv;          v.ft = ft;      v.frt = frt;    v.e_ready = er;
        v.e_cv = ecv;       v.e_ct = ect;   v.e_cd = ecd;   v.e_cs = ecs;
        vecs.push_back(v);
    endtask

    task automatic idle();
        bus.req_valid      = '0;
        bus.req_tag        = '0;
        bus.req_data       = '0;
        bus.flush_valid    = 1'b0;
        bus.flush_tag      = '0;
        bus.flush_rear_tag = '0;
    endtask

    // Entered at posedge+1; returns at posedge+1 after one clean edge out of reset.
    task automatic pulse_reset();
        idle();
        rst = 1'b0;
        #2;
        chk("reset cdb_valid", bus.cdb_valid, 0);
        chk("reset req_ready", bus.req_ready, 4'hf);
        chk("reset cdb_tag", bus.cdb_tag, 0);
        chk("reset cdb_data", bus.cdb_data, 0);
        chk("reset cdb_src", bus.cdb_src, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_row(input vec_t v, input int r);
        if (v.rst_first) pulse_reset();
        bus.req_valid      = v.valid;
        bus.req_tag        = v.tag;
        bus.req_data       = v.data;
        bus.flush_valid    = v.fv;
        bus.flush_tag      = v.ft;
        bus.flush_rear_tag = v.frt;
        #2;
        chk($sformatf("row%0d req_ready", r), bus.req_ready, v.e_ready);
        @(posedge clk);
        #1;
        chk($sformatf("row%0d cdb_valid", r), bus.cdb_valid, v.e_cv);
        chk($sformatf("row%0d cdb_tag", r), bus.cdb_tag, v.e_ct);
        chk($sformatf("row%0d cdb_data", r), bus.cdb_data, v.e_cd);
        chk($sformatf("row%0d cdb_src", r), bus.cdb_src, v.e_cs);
        $display("row %0d: valid=%b ready=%b cdb_valid=%0d tag=%0d src=%0d data=%h",
                 r, v.valid, bus.req_ready, bus.cdb_valid, bus.cdb_tag, bus.cdb_src, bus.cdb_data);
    endtask

    task automatic fill_table();
        // Single result from unit 2
        add_row(1, 4'b0100, 16'h0500, {32'h0, 32'hDEADBEEF, 64'h0}, 0, 0, 0, 4'hf, 0, 0, 0, 0);
        add_row(0, 4'b0000, 16'h0000, 128'h0, 0, 0, 0, 4'hf, 1, 5, 32'hDEADBEEF, 2);
        add_row(0, 4'b0000, 16'h0000, 128'h0, 0, 0, 0, 4'hf, 0, 5, 32'hDEADBEEF, 2);
        // Contention, tags 1..4 from rr_ptr 0
        add_row(1, 4'b1111, 16'h4321, dd(16'h4321), 0, 0, 0, 4'hf, 0, 0, 0, 0);
        add_row(0, 4'b0000, 16'h0000, 128'h0, 0, 0, 0, 4'b0001, 1, 1, dv(0, 1), 0);
        add_row(0, 4'b0000, 16'h0000, 128'h0, 0, 0, 0, 4'b0011, 1, 2, dv(1, 2), 1);
        add_row(0, 4'b0000, 16'h0000, 128'h0, 0, 0, 0, 4'b0111, 1, 3, dv(2, 3), 2);
        add_row(0, 4'b0000, 16'h0000, 128'h0, 0, 0, 0, 4'hf, 1, 4, dv(3, 4), 3);
        add_row(0, 4'b0000, 16'h0000, 128'h0, 0, 0, 0, 4'hf, 0, 4, dv(3, 4), 3);
        add_row(0, 4'b1010, 16'h6050, dd(16'h6050), 0, 0, 0, 4'hf, 0, 4, dv(3, 4), 3);
        add_row(0, 4'b0000, 16'h0000, 128'h0, 0, 0, 0, 4'b0111, 1, 5, dv(1, 5), 1);
        add_row(0, 4'b0000, 16'h0000, 128'h0, 0, 0, 0, 4'hf, 1, 6, dv(3, 6), 3);
        add_row(0, 4'b0000, 16'h0000, 128'h0, 0, 0, 0, 4'hf, 0, 6, dv(3, 6), 3);
        // Streaming tags 0..7 from unit 0
        for (int k = 0; k < 8; k++) begin
            if (k == 0)
                add_row(1, 4'b0001, 16'h0000, dd(16'h0000), 0, 0, 0, 4'hf, 0, 0, 0, 0);
            else
                add_row(0, 4'b0001, {12'h0, 4'(k)}, dd({12'h0, 4'(k)}), 0, 0, 0, 4'hf,
                        1, 4'(k - 1), dv(0, 4'(k - 1)), 0);
        end
        add_row(0, 4'b0000, 16'h0000, 128'h0, 0, 0, 0, 4'hf, 1, 7, dv(0, 7), 0);
        add_row(0, 4'b0000, 16'h0000, 128'h0, 0, 0, 0, 4'hf, 0, 7, dv(0, 7), 0);
        // Flush 5..7: buffered tag 6 and incoming tag 6 dropped, tag 3 survives
        add_row(1, 4'b0011, 16'h0063, dd(16'h0063), 0, 0, 0, 4'hf, 0, 0, 0, 0);
        add_row(0, 4'b0100, 16'h0600, dd(16'h0600), 1, 5, 7, 4'b1101, 1, 3, dv(0, 3), 0);
        add_row(0, 4'b0000, 16'h0000, 128'h0, 0, 0, 0, 4'hf, 0, 3, dv(0, 3), 0);
        add_row(0, 4'b0000, 16'h0000, 128'h0, 0, 0, 0, 4'hf, 0, 3, dv(0, 3), 0);
        // Empty flush range 4..3 squashes nothing
        add_row(1, 4'b0011, 16'h0074, dd(16'h0074), 0, 0, 0, 4'hf, 0, 0, 0, 0);
        add_row(0, 4'b0000, 16'h0000, 128'h0, 1, 4, 3, 4'b1101, 1, 4, dv(0, 4), 0);
        add_row(0, 4'b0000, 16'h0000, 128'h0, 1, 4, 3, 4'hf, 1, 7, dv(1, 7), 1);
        add_row(0, 4'b0000, 16'h0000, 128'h0, 0, 0, 0, 4'hf, 0, 7, dv(1, 7), 1);
    endtask

    task automatic mid_reset_seq();
        pulse_reset();
        bus.req_valid = 4'b0011;
        bus.req_tag   = 16'h0032;
        bus.req_data  = dd(16'h0032);
        #2;
        @(posedge clk);
        #1;
        idle();
        @(posedge clk);
        #1;
        chk("midrst pre cdb_valid", bus.cdb_valid, 1);
        chk("midrst pre req_ready", bus.req_ready, 4'hf);
        rst = 1'b0;
        #1;
        chk("midrst cdb_valid", bus.cdb_valid, 0);
        chk("midrst req_ready", bus.req_ready, 4'hf);
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            chk("midrst post cdb_valid", bus.cdb_valid, 0);
        end
        $display("mid-operation reset: cdb_valid=%0d ready=%b", bus.cdb_valid, bus.req_ready);
    endtask

    task automatic random_phase(input int cycles);
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            m_full[i] = 0;
            m_tag[i]  = '0;
            m_data[i] = '0;
        end
        m_ptr = 0; m_cv = 0; m_ct = '0; m_cd = '0; m_cs = '0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            int         g;
            logic [3:0] er;
            bus.req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                bus.req_tag[i]  = 4'($urandom_range(0, 7));
                bus.req_data[i] = $urandom;
            end
            bus.flush_valid    = ($urandom_range(0, 5) == 0);
            bus.flush_tag      = 4'($urandom_range(0, 7));
            bus.flush_rear_tag = 4'($urandom_range(0, 7));
            #2;
            g = -1;
            for (int k = 0; k < 4; k++) begin
                int u;
                u = (m_ptr + k) % 4;
                if (g < 0 && m_full[u] &&
                    !in_flush(m_tag[u], bus.flush_tag, bus.flush_rear_tag, bus.flush_valid))
                    g = u;
            end
            for (int i = 0; i < 4; i++) er[i] = !m_full[i] || (g == i);
            chk("rnd req_ready", bus.req_ready, er);
            if (g >= 0) begin
                m_cv = 1; m_ct = m_tag[g]; m_cd = m_data[g]; m_cs = 2'(g);
                m_ptr = (g + 1) % 4;
            end else begin
                m_cv = 0;
            end
            for (int i = 0; i < 4; i++) begin
                if (bus.req_valid[i] && er[i] &&
                    !in_flush(bus.req_tag[i], bus.flush_tag, bus.flush_rear_tag, bus.flush_valid)) begin
                    m_full[i] = 1;
                    m_tag[i]  = bus.req_tag[i];
                    m_data[i] = bus.req_data[i];
                end else if (g == i ||
                             (m_full[i] && in_flush(m_tag[i], bus.flush_tag,
                                                    bus.flush_rear_tag, bus.flush_valid))) begin
                    m_full[i] = 0;
                end
            end
            @(posedge clk);
            #1;
            chk("rnd cdb_valid", bus.cdb_valid, m_cv);
            chk("rnd cdb_tag", bus.cdb_tag, m_ct);
            chk("rnd cdb_data", bus.cdb_data, m_cd);
            chk("rnd cdb_src", bus.cdb_src, m_cs);
            if (m_cv)
                $display("rnd %0d: broadcast tag=%0d src=%0d data=%h",
                         cyc, bus.cdb_tag, bus.cdb_src, bus.cdb_data);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        idle();
        #2;
        chk("initial cdb_valid", bus.cdb_valid, 0);
        chk("initial req_ready", bus.req_ready, 4'hf);
        @(posedge clk);
        #1;
        fill_table();
        for (int r = 0; r < vecs.size(); r++) run_row(vecs[r], r);
        mid_reset_seq();
        random_phase(1500);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
